// File: rtl/stopwatch_timer_counter_if.sv
// Host-side bundle for the stopwatch elapsed-time core: tick/run/clear controls in,
// millisecond and seconds fields out.
interface stopwatch_timer_counter_if;
  localparam int unsigned MS_W  = 10;
  localparam int unsigned SEC_W = 6;

  logic             I_EN_1MS;
  logic             I_CLEAR_EN;
  logic             I_START_EN;
  logic [MS_W-1:0]  O_TIMER_MS;
  logic [SEC_W-1:0] O_TIMER_SEC;

  modport master (
    output I_EN_1MS, I_CLEAR_EN, I_START_EN,
    input  O_TIMER_MS, O_TIMER_SEC
  );

  modport slave (
    input  I_EN_1MS, I_CLEAR_EN, I_START_EN,
    output O_TIMER_MS, O_TIMER_SEC
  );
endinterface

// File: rtl/stopwatch_timer_counter.sv
// Elapsed-time core: counts 1 ms tick strobes into a binary ms field (0..999) and a
// seconds field (0..59) that wraps silently; clear beats tick, run enable gates ticks.
module stopwatch_timer_counter (
  input  logic                      I_CLK,
  input  logic                      I_RSTN,
  stopwatch_timer_counter_if.slave  tif
);
  localparam int unsigned MS_W    = 10;
  localparam int unsigned SEC_W   = 6;
  localparam int unsigned MS_MAX  = 999;
  localparam int unsigned SEC_MAX = 59;

  logic [MS_W-1:0]  ms_q;
  logic [SEC_W-1:0] sec_q;
  logic             tick_c;
  logic             ms_wrap_c;
  logic             sec_wrap_c;

  // ">=" so an out-of-range field is treated as terminal and wraps on the next tick
  always_comb begin
    tick_c     = tif.I_START_EN & tif.I_EN_1MS;
    ms_wrap_c  = (ms_q  >= MS_W'(MS_MAX));
    sec_wrap_c = (sec_q >= SEC_W'(SEC_MAX));
  end

  // ms and sec share one edge so the carry is never visible half-applied
  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      ms_q  <= '0;
      sec_q <= '0;
    end else if (tif.I_CLEAR_EN) begin
      ms_q  <= '0;
      sec_q <= '0;
    end else if (tick_c) begin
      if (ms_wrap_c) begin
        ms_q  <= '0;
        sec_q <= sec_wrap_c ? '0 : sec_q + SEC_W'(1);
      end else begin
        ms_q  <= ms_q + MS_W'(1);
      end
    end
  end

  assign tif.O_TIMER_MS  = ms_q;
  assign tif.O_TIMER_SEC = sec_q;
endmodule

// File: tb/tb_stopwatch_timer_counter.sv
// Randomised bench for stopwatch_timer_counter against an elapsed-milliseconds model
// (ms = total mod 1000, sec = total div 1000, total wrapping at 60 000).
module tb_stopwatch_timer_counter;
  logic I_CLK  = 1'b0;
  logic I_RSTN = 1'b0;

  stopwatch_timer_counter_if tif ();

  stopwatch_timer_counter dut (
    .I_CLK  (I_CLK),
    .I_RSTN (I_RSTN),
    .tif    (tif.slave)
  );

  always #5 I_CLK = ~I_CLK;

  int          n_checks   = 0;
  int          n_fail     = 0;
  int unsigned elapsed_ms = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
    n_checks++;
    if (got !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_ms"},  32'(tif.O_TIMER_MS),  int'(elapsed_ms % 1000));
    check_eq({tag, "_sec"}, 32'(tif.O_TIMER_SEC), int'(elapsed_ms / 1000));
  endtask

  // One clock: drive inputs, advance the model on the edge, land 1 time unit past it
  task automatic cycle(input logic en, input logic start, input logic clr);
    tif.I_EN_1MS   = en;
    tif.I_START_EN = start;
    tif.I_CLEAR_EN = clr;
    @(posedge I_CLK);
    if (I_RSTN) begin
      if (clr)               elapsed_ms = 0;
      else if (en && start)  elapsed_ms = (elapsed_ms + 1) % 60000;
    end
    #1;
  endtask

  task automatic ticks(input int n, input int gap_max);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      repeat ($urandom_range(0, gap_max)) cycle(1'b0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    tif.I_EN_1MS   = 1'b1;
    tif.I_START_EN = 1'b1;
    tif.I_CLEAR_EN = 1'b0;
    #1;
    check_outputs("reset_initial");
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      check_outputs("reset_hold");
    end

    I_RSTN = 1'b1;
    cycle(1'b1, 1'b1, 1'b0);
    check_outputs("first_tick");

    // Second carry with irregular tick spacing up to 16 cycles
    ticks(998, 15);
    check_outputs("pre_carry");
    ticks(1, 15);
    check_outputs("sec_carry");

    // Back-to-back strobes through the full 60 s wrap
    ticks(58999, 0);
    check_outputs("pre_wrap");
    ticks(1, 0);
    check_outputs("full_wrap");

    cycle(1'b0, 1'b1, 1'b1);
    check_outputs("clear_idle");
    ticks(500, 0);
    check_outputs("pre_hold");
    for (int i = 0; i < 100; i++) cycle(1'b1, 1'b0, 1'b0);
    check_outputs("hold");
    cycle(1'b1, 1'b1, 1'b0);
    check_outputs("resume");

    // Asynchronous reset between edges at sec = 7
    ticks(6500, 0);
    check_outputs("pre_reset");
    #2;
    I_RSTN     = 1'b0;
    #1;
    elapsed_ms = 0;
    check_outputs("async_reset");
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0);
    check_outputs("reset_low");
    I_RSTN = 1'b1;
    cycle(1'b1, 1'b1, 1'b0);
    check_outputs("post_reset");

    // Clear coincident with a tick at 3.250 s
    ticks(3249, 0);
    check_outputs("pre_clear");
    cycle(1'b1, 1'b1, 1'b1);
    check_outputs("clear_with_tick");
    cycle(1'b1, 1'b1, 1'b0);
    check_outputs("after_clear");

    // Random traffic starting just below a seconds carry
    ticks(995, 0);
    for (int i = 0; i < 1500; i++) begin
      cycle(1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 127) == 0));
      check_outputs("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
